// File: rtl/mem_lsu_pkg.sv
// Shared constants, funct3 encodings, FSM state type and decode helpers for the MEM-stage LSU.
package mem_lsu_pkg;

  // Pipeline-wide widths
  localparam int unsigned REG_DATA_WIDTH  = 32;
  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam int unsigned WSTRB_WIDTH     = 4;

  // funct3 load/store size and sign encodings
  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  // funct3[1:0] size field
  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitRsp = 2'd2
  } lsu_state_e;

  // Only the five architected encodings are accepted; 011 and 11x raise mem_err.
  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3B) || (f3 == F3H) || (f3 == F3W) || (f3 == F3Bu) || (f3 == F3Hu);
    return ok;
  endfunction

  // Natural alignment for the access size; bytes are always aligned.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    unique case (f3[1:0])
      SzHalf:  ok = ~off[0];
      SzWord:  ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/response port between the LSU (master) and data memory (slave).
interface mem_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import mem_lsu_pkg::*;

  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_we;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic [DATA_WIDTH-1:0]  mem_req_wdata;
  logic [WSTRB_WIDTH-1:0] mem_req_wstrb;
  logic                   mem_resp_valid;
  logic [DATA_WIDTH-1:0]  mem_resp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_wdata,
    output mem_req_wstrb,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_wdata,
    input  mem_req_wstrb,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_rdata
  );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store data replication/byte strobes and load extract/extend.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]                st_size,
  input  logic [1:0]                st_off,
  input  logic [REG_DATA_WIDTH-1:0] store_data,
  output logic [REG_DATA_WIDTH-1:0] wdata,
  output logic [WSTRB_WIDTH-1:0]    wstrb,
  input  logic [2:0]                ld_funct3,
  input  logic [1:0]                ld_off,
  input  logic [REG_DATA_WIDTH-1:0] rdata,
  output logic [REG_DATA_WIDTH-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store path: replicate the operand across all lanes, enable only the addressed bytes.
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    unique case (st_size)
      SzByte: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << st_off;
      end
      SzHalf: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << st_off;
      end
      default: ;
    endcase
  end

  // Load path: pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    byte_sel = rdata[8*ld_off +: 8];
    half_sel = rdata[16*ld_off[1] +: 16];
    case (ld_funct3)
      F3B:     ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3Bu:    ld_data = {24'b0, byte_sel};
      F3H:     ld_data = {{16{half_sel[15]}}, half_sel};
      F3Hu:    ld_data = {16'b0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues word-aligned memory requests, stalls the pipeline while an
// access is outstanding, and returns aligned/extended load data to MEM/WB.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = INST_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  mem_lsu_if.master             mem,
  output logic                  mem_stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  mem_err
);

  lsu_state_e             state_q;
  logic                   req_valid_q;
  logic                   req_we_q;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [DATA_WIDTH-1:0]  req_wdata_q;
  logic [WSTRB_WIDTH-1:0] req_wstrb_q;
  logic [2:0]             ld_f3_q;
  logic [1:0]             ld_off_q;
  logic                   load_valid_q;
  logic [DATA_WIDTH-1:0]  load_data_q;
  logic                   mem_err_q;

  logic                   one_op;
  logic                   both_ops;
  logic                   f3_ok;
  logic                   align_ok;
  logic                   start;
  logic                   bad_access;
  logic [DATA_WIDTH-1:0]  align_wdata;
  logic [WSTRB_WIDTH-1:0] align_wstrb;
  logic [DATA_WIDTH-1:0]  align_ld_data;

  // Decode the instruction currently held in EX/MEM.
  always_comb begin
    one_op     = MemRead ^ MemWrite;
    both_ops   = MemRead & MemWrite;
    f3_ok      = f3_legal(funct3);
    align_ok   = addr_aligned(funct3, ALU_result[1:0]);
    start      = in_valid & one_op & f3_ok & align_ok;
    bad_access = in_valid & (both_ops | (one_op & ~(f3_ok & align_ok)));
  end

  // Store lanes are computed from the live operands and latched at issue; load extraction uses
  // the offset/funct3 latched at issue, since EX/MEM may not be trusted after the stall drops.
  mem_align u_align (
    .st_size    (funct3[1:0]),
    .st_off     (ALU_result[1:0]),
    .store_data (store_data),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .ld_funct3  (ld_f3_q),
    .ld_off     (ld_off_q),
    .rdata      (mem.mem_resp_rdata),
    .ld_data    (align_ld_data)
  );

  // Access FSM with registered request, load result and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
      ld_f3_q      <= F3W;
      ld_off_q     <= 2'b00;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
            req_we_q    <= MemWrite;
            req_addr_q  <= {ALU_result[ADDR_WIDTH-1:2], 2'b00};
            req_wdata_q <= align_wdata;
            req_wstrb_q <= align_wstrb;
            ld_f3_q     <= funct3;
            ld_off_q    <= ALU_result[1:0];
          end else if (bad_access) begin
            mem_err_q <= 1'b1;
          end
        end
        StReq: begin
          if (mem.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= req_we_q ? StIdle : StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (mem.mem_resp_valid) begin
            load_data_q  <= align_ld_data;
            load_valid_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall drops in the completion cycle so EX/MEM advances on the same edge the FSM idles.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle:    mem_stall = start;
      StReq:     mem_stall = ~(req_we_q & mem.mem_req_ready);
      StWaitRsp: mem_stall = ~mem.mem_resp_valid;
      default:   mem_stall = 1'b0;
    endcase
  end

  // Drive registered outputs.
  always_comb begin
    mem.mem_req_valid = req_valid_q;
    mem.mem_req_we    = req_we_q;
    mem.mem_req_addr  = req_addr_q;
    mem.mem_req_wdata = req_wdata_q;
    mem.mem_req_wstrb = req_wstrb_q;
    load_valid        = load_valid_q;
    load_data         = load_data_q;
    mem_err           = mem_err_q;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit of the MEM stage, directly downstream of EX.
- Consumes the EX/MEM-registered ALU result as the effective address and the forwarded rs2 value as store data.
- Issues word-aligned requests on a valid/ready data-memory port, then aligns and sign/zero-extends load data for MEM/WB.
- Drives a stall back to the hazard logic while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, effective address width (matches INST_ADDR_WIDTH).
- DATA_WIDTH, 32, register/memory data width (matches REG_DATA_WIDTH); only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  EX/MEM holds a valid instruction.
- MemRead  input  1  load control from EX/MEM.
- MemWrite  input  1  store control from EX/MEM.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALU_result  input  ADDR_WIDTH  effective byte address.
- store_data  input  DATA_WIDTH  forwarded rs2 value.
- mem_req_valid  output  1  request to data memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_we  output  1  1 = write.
- mem_req_addr  output  ADDR_WIDTH  word address, ALU_result with [1:0] = 00.
- mem_req_wdata  output  DATA_WIDTH  lane-replicated store data.
- mem_req_wstrb  output  4  byte enables.
- mem_resp_valid  input  1  read data valid (loads only).
- mem_resp_rdata  input  DATA_WIDTH  read word.
- mem_stall  output  1  freeze IF/ID/EX and EX/MEM.
- load_valid  output  1  one-cycle pulse: load_data is valid.
- load_data  output  DATA_WIDTH  aligned, extended load result.
- mem_err  output  1  one-cycle pulse on misaligned or illegal access.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - mem_req_valid, load_valid, mem_err = 0.
  - load_data = 0.
- Reset is asynchronous and may assert mid-access. It returns the FSM to IDLE and drops any outstanding access. The memory shares rst_n.
- States: IDLE, REQ, WAIT_RSP.
- An access starts when in_valid & (MemRead ^ MemWrite) & aligned.
- Alignment:
  - H/HU require addr[0] = 0.
  - W requires addr[1:0] = 00.
  - B/BU are always aligned.
- Errors:
  - The following produce mem_err = 1 for one cycle, with no request and no stall:
    - misaligned address;
    - MemRead & MemWrite together;
    - unsupported funct3 (011, 11x).
  - mem_err is registered; it pulses the cycle after the instruction is presented.
  - The FSM stays in IDLE.
- IDLE: on start, go to REQ. mem_req_valid is registered, so it asserts the cycle after the instruction is presented.
- REQ:
  - mem_req_valid = 1, with all request fields held stable until mem_req_ready.
  - On ready with a store: the store completes and the FSM goes to IDLE.
  - On ready with a load: go to WAIT_RSP.
  - ready low: stay in REQ.
- WAIT_RSP:
  - On mem_resp_valid: register load_data, pulse load_valid next cycle, go to IDLE.
  - A response arriving in the same cycle as acceptance is not legal. Memory latency is at least 1 cycle.
- mem_stall is combinational:
  - high while a start condition exists and the access has not completed;
  - low in the completion cycle, i.e. store accept, or load response;
  - the store-accept case is a combinational path from mem_req_ready.
- Pipeline contract: EX/MEM advances at the clock edge where mem_stall = 0. The FSM re-enters IDLE at that same edge, so an instruction is never issued twice.
- Store data/strobes (wdata = size-replicated store_data):
  - SB: wdata = {4{store_data[7:0]}}; wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{store_data[15:0]}}; wstrb = 0011 << addr[1:0].
  - SW: wdata = store_data; wstrb = 1111.
- Loads:
  - Select the byte at rdata[8*addr[1:0] +: 8] or the half at rdata[16*addr[1] +: 16].
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Offset and funct3 are latched at request time.
- A mem_resp_valid seen in IDLE or REQ is ignored.
- in_valid = 0 or no memory op: no stall, no request.

Decomposition:
- Shared const package entries:
  - funct3 load/store encodings;
  - FSM state encoding (2-bit);
  - WSTRB width (4);
  - existing REG_DATA_WIDTH and INST_ADDR_WIDTH.
- Sub-module: mem_align, a combinational block for store lane replication/strobes and load extract/extend. Instantiated once; the FSM stays in mem_lsu.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, ready tied 1:
  - req at cycle +1 with addr 0x100, wstrb 1111, we = 1;
  - stall low in the accept cycle; exactly one request.
- SB, addr 0x103, data 0x000000A5, ready delayed 3 cycles:
  - wdata 0xA5A5A5A5, wstrb 1000, fields stable while waiting;
  - stall held for all waiting cycles.
- LB, addr 0x202, resp rdata 0x12F45678 after 2 cycles:
  - load_data 0xFFFFFFF4, load_valid pulses once.
- Same word, LHU, addr 0x202:
  - load_data 0x000012F4.
- LW at 0x101, then SH at 0x003:
  - mem_err pulses each time;
  - no mem_req_valid and no stall.
- rst_n low while in WAIT_RSP:
  - outputs go to reset values immediately;
  - a later resp_valid is ignored;
  - the next LW at 0x0 completes normally.
